// File: rtl/dram_cmd_sched.sv
// dram_cmd_sched: single-bank DRAM command scheduler fed by the request FIFO.
// Pops one request at a time, opens/closes rows with an open-page policy,
// enforces tRCD/tRP/tRAS/tRFC and inserts a refresh every T_REFI cycles.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-low reset
//   fifo_empty      FIFO empty flag, looked at only while idle
//   fifo_data       FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en      one-cycle pop strobe
//   cmd, cmd_addr   registered command pulse (0 NOP 1 ACT 2 RD 3 WR 4 PRE 5 REF)
//                   with row (ACT) or column (RD/WR), 0 otherwise
//   row_open        a row is open in the bank
//   busy            FSM is not idle
//   dbg_state       current FSM state
//
// FIFO handshake: fifo_rd_en is high for exactly one cycle (the POP state);
// the FIFO presents the popped word on fifo_data during the following cycle
// (DECODE), where it is captured. No pop is issued while a request is in flight.
//
// All outputs are flops loaded from the next-state decode, so a command is
// visible on cmd during the cycle in which the FSM sits in the issuing state.
module dram_cmd_sched #(
  parameter int ROW_W  = 4,
  parameter int COL_W  = 3,
  parameter int REQ_W  = 1 + ROW_W + COL_W,
  parameter int ADDR_W = (ROW_W > COL_W) ? ROW_W : COL_W,
  parameter int T_RCD  = 3,
  parameter int T_RP   = 3,
  parameter int T_RAS  = 6,
  parameter int T_RFC  = 8,
  parameter int T_REFI = 200
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  input  logic [REQ_W-1:0]  fifo_data,
  output logic              fifo_rd_en,
  output logic [2:0]        cmd,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic              row_open,
  output logic              busy,
  output logic [3:0]        dbg_state
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_POP      = 4'd1;
  localparam logic [3:0] S_DECODE   = 4'd2;
  localparam logic [3:0] S_PRE      = 4'd3;
  localparam logic [3:0] S_WAIT_RP  = 4'd4;
  localparam logic [3:0] S_ACT      = 4'd5;
  localparam logic [3:0] S_WAIT_RCD = 4'd6;
  localparam logic [3:0] S_RW       = 4'd7;
  localparam logic [3:0] S_REF      = 4'd8;
  localparam logic [3:0] S_WAIT_RFC = 4'd9;

  localparam logic [2:0] CMD_NOP = 3'd0;
  localparam logic [2:0] CMD_ACT = 3'd1;
  localparam logic [2:0] CMD_RD  = 3'd2;
  localparam logic [2:0] CMD_WR  = 3'd3;
  localparam logic [2:0] CMD_PRE = 3'd4;
  localparam logic [2:0] CMD_REF = 3'd5;

  localparam int TMR_W = 8;
  localparam int RC_W  = $clog2(T_REFI);

  logic [3:0]        state_q, state_d;
  logic [REQ_W-1:0]  req_q, req_d;
  logic              req_vld_q, req_vld_d;
  logic              row_open_q, row_open_d;
  logic [ROW_W-1:0]  open_row_q, open_row_d;
  logic [TMR_W-1:0]  tras_q, tras_d, trp_q, trp_d, trcd_q, trcd_d, trfc_q, trfc_d;
  logic [RC_W-1:0]   ref_cnt_q, ref_cnt_d;
  logic              ref_pend_q, ref_pend_d;
  logic [2:0]        cmd_q, cmd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_en_q, rd_en_d;
  logic              busy_q, busy_d;

  function automatic logic [TMR_W-1:0] sat_dec(input logic [TMR_W-1:0] v);
    return (v == '0) ? v : v - TMR_W'(1);
  endfunction

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    req_vld_d  = req_vld_q;
    row_open_d = row_open_q;
    open_row_d = open_row_q;
    tras_d     = sat_dec(tras_q);
    trp_d      = sat_dec(trp_q);
    trcd_d     = sat_dec(trcd_q);
    trfc_d     = sat_dec(trfc_q);
    ref_pend_d = ref_pend_q;
    cmd_d      = CMD_NOP;
    addr_d     = '0;
    rd_en_d    = 1'b0;

    // Transitions look at the decremented timers so the issuing state is
    // entered exactly on the first legal cycle.
    case (state_q)
      S_IDLE: begin
        if (ref_pend_q) begin
          if (row_open_q)        state_d = S_PRE;
          else if (trp_d == '0)  state_d = S_REF;
        end else if (!fifo_empty) begin
          state_d = S_POP;
        end
      end
      S_POP:    state_d = S_DECODE;
      S_DECODE: begin
        req_d     = fifo_data;
        req_vld_d = 1'b1;
        if (row_open_q && (fifo_data[COL_W +: ROW_W] == open_row_q)) state_d = S_RW;
        else if (row_open_q)                                        state_d = S_PRE;
        else                                                        state_d = S_ACT;
      end
      // PRE may sit here with NOP until tRAS has elapsed.
      S_PRE:      if (cmd_q == CMD_PRE) state_d = S_WAIT_RP;
      // An in-flight request finishes before the pending refresh.
      S_WAIT_RP:  if (trp_d == '0) state_d = req_vld_q ? S_ACT : S_REF;
      S_ACT:      state_d = S_WAIT_RCD;
      S_WAIT_RCD: if (trcd_d == '0) state_d = S_RW;
      S_RW:       state_d = S_IDLE;
      S_REF:      state_d = S_WAIT_RFC;
      S_WAIT_RFC: if (trfc_d == '0) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase

    // Command issue follows the state being entered.
    case (state_d)
      S_POP: rd_en_d = 1'b1;
      S_PRE: begin
        if (tras_d == '0) begin
          cmd_d      = CMD_PRE;
          row_open_d = 1'b0;
          trp_d      = TMR_W'(T_RP);
        end
      end
      S_ACT: begin
        cmd_d      = CMD_ACT;
        addr_d     = ADDR_W'(req_d[COL_W +: ROW_W]);
        row_open_d = 1'b1;
        open_row_d = req_d[COL_W +: ROW_W];
        tras_d     = TMR_W'(T_RAS);
        trcd_d     = TMR_W'(T_RCD);
      end
      S_RW: begin
        cmd_d     = req_d[REQ_W-1] ? CMD_WR : CMD_RD;
        addr_d    = ADDR_W'(req_d[COL_W-1:0]);
        req_vld_d = 1'b0;
      end
      S_REF: begin
        cmd_d      = CMD_REF;
        trfc_d     = TMR_W'(T_RFC);
        ref_pend_d = 1'b0;
      end
      default: ;
    endcase

    // Expiry wins over a same-cycle REF clear; repeated expiries do not queue.
    if (ref_cnt_q == RC_W'(T_REFI - 1)) begin
      ref_cnt_d  = '0;
      ref_pend_d = 1'b1;
    end else begin
      ref_cnt_d  = ref_cnt_q + RC_W'(1);
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      req_q      <= '0;
      req_vld_q  <= 1'b0;
      row_open_q <= 1'b0;
      open_row_q <= '0;
      tras_q     <= '0;
      trp_q      <= '0;
      trcd_q     <= '0;
      trfc_q     <= '0;
      ref_cnt_q  <= '0;
      ref_pend_q <= 1'b0;
      cmd_q      <= CMD_NOP;
      addr_q     <= '0;
      rd_en_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      req_vld_q  <= req_vld_d;
      row_open_q <= row_open_d;
      open_row_q <= open_row_d;
      tras_q     <= tras_d;
      trp_q      <= trp_d;
      trcd_q     <= trcd_d;
      trfc_q     <= trfc_d;
      ref_cnt_q  <= ref_cnt_d;
      ref_pend_q <= ref_pend_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      rd_en_q    <= rd_en_d;
      busy_q     <= busy_d;
    end
  end

  assign fifo_rd_en = rd_en_q;
  assign cmd        = cmd_q;
  assign cmd_addr   = addr_q;
  assign row_open   = row_open_q;
  assign busy       = busy_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_dram_cmd_sched.sv
// tb_dram_cmd_sched: directed bench for dram_cmd_sched with a small FIFO
// model, a negedge monitor logging pops and commands, and an expected queue
// of {cmd, addr} words checked against the log in order.
module tb_dram_cmd_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_rd_en;
  logic [2:0] cmd;
  logic [3:0] cmd_addr;
  logic       row_open;
  logic       busy;
  logic [3:0] dbg_state;

  dram_cmd_sched dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .cmd        (cmd),
    .cmd_addr   (cmd_addr),
    .row_open   (row_open),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // ---------------- FIFO model ----------------
  logic       rand_mode = 1'b1;
  logic       rand_empty = 1'b1;
  logic [7:0] rand_data = 8'h00;
  logic [7:0] fifo_mem [0:31];
  logic [7:0] fifo_dout = 8'h00;
  int         pushed_n = 0;
  int         popped_n = 0;
  logic       pop_now;

  assign fifo_empty = rand_mode ? rand_empty : (pushed_n == popped_n);
  assign fifo_data  = rand_mode ? rand_data  : fifo_dout;

  always @(posedge clk) begin
    pop_now = fifo_rd_en && rst;
    #1;
    if (pop_now && (pushed_n != popped_n)) begin
      fifo_dout = fifo_mem[popped_n % 32];
      popped_n  = popped_n + 1;
    end
  end

  // ---------------- monitor ----------------
  int pop_log[$];
  int cmd_cyc_log[$];
  int cmd_val_log[$];
  int cmd_adr_log[$];

  always @(negedge clk) begin
    if (fifo_rd_en) pop_log.push_back(cyc);
    if (cmd != 3'd0) begin
      cmd_cyc_log.push_back(cyc);
      cmd_val_log.push_back(int'(cmd));
      cmd_adr_log.push_back(int'(cmd_addr));
    end
  end

  // ---------------- scoreboard ----------------
  logic [6:0] exp_q[$];
  int pop_rd = 0;
  int cmd_rd = 0;
  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic push_req(input logic [7:0] w);
    @(negedge clk);
    fifo_mem[pushed_n % 32] = w;
    pushed_n = pushed_n + 1;
  endtask

  task automatic wait_pop(input string tag, output int c);
    int n;
    n = 0;
    c = -1;
    while (pop_log.size() <= pop_rd && n < 400) begin
      @(posedge clk);
      n++;
    end
    chk({tag, "_seen"}, int'(pop_log.size() > pop_rd), 1);
    if (pop_log.size() > pop_rd) begin
      c = pop_log[pop_rd];
      pop_rd++;
    end
  endtask

  task automatic expect_cmd(input string tag, input int exp_cyc, output int cyc_o);
    logic [6:0] e;
    int n;
    e = exp_q.pop_front();
    n = 0;
    cyc_o = -1;
    while (cmd_cyc_log.size() <= cmd_rd && n < 400) begin
      @(posedge clk);
      n++;
    end
    chk({tag, "_seen"}, int'(cmd_cyc_log.size() > cmd_rd), 1);
    if (cmd_cyc_log.size() > cmd_rd) begin
      cyc_o = cmd_cyc_log[cmd_rd];
      chk({tag, "_cmd"}, cmd_val_log[cmd_rd], int'(e[6:4]));
      chk({tag, "_addr"}, cmd_adr_log[cmd_rd], int'(e[3:0]));
      if (exp_cyc >= 0) chk({tag, "_cyc"}, cyc_o, exp_cyc);
      cmd_rd++;
    end
  endtask

  // ---------------- stimulus ----------------
  int p, a, r, pre, a2, rf;
  int b2b_pop [4];
  logic [2:0] b2b_col [4];

  initial begin
    b2b_col[0] = 3'd0; b2b_col[1] = 3'd2; b2b_col[2] = 3'd4; b2b_col[3] = 3'd7;

    // Reset held with random FIFO inputs
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      rand_empty = 1'($urandom_range(0, 1));
      rand_data  = 8'($urandom_range(0, 255));
    end
    @(negedge clk);
    chk("rst_cmd", cmd, 0);
    chk("rst_addr", cmd_addr, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_row_open", row_open, 0);
    chk("rst_busy", busy, 0);
    chk("rst_state", dbg_state, 0);
    rand_mode = 1'b0;
    rst = 1'b1;

    // Cold read: 0x2D = rd row 5 col 5
    push_req(8'h2D);
    wait_pop("cold_pop", p);
    exp_q.push_back({3'd1, 4'd5}); expect_cmd("cold_act", p + 2, a);
    exp_q.push_back({3'd2, 4'd5}); expect_cmd("cold_rd", p + 5, r);
    @(negedge clk);
    chk("cold_row_open", row_open, 1);

    // Row hit write: 0xAB = wr row 5 col 3
    push_req(8'hAB);
    wait_pop("hit_pop", p);
    exp_q.push_back({3'd3, 4'd3}); expect_cmd("hit_wr", p + 2, r);

    // Row miss: 0x39 = rd row 7 col 1
    push_req(8'h39);
    wait_pop("miss_pop", p);
    exp_q.push_back({3'd4, 4'd0}); expect_cmd("miss_pre", p + 2, pre);
    chk("miss_pre_after_ras", int'(pre - a >= 6), 1);
    exp_q.push_back({3'd1, 4'd7}); expect_cmd("miss_act", pre + 3, a2);
    exp_q.push_back({3'd2, 4'd1}); expect_cmd("miss_rd", a2 + 3, r);
    @(negedge clk);
    chk("miss_row_open", row_open, 1);
    chk("miss_busy_idle", busy, 0);

    // Refresh with row 7 open and FIFO empty
    exp_q.push_back({3'd4, 4'd0}); expect_cmd("ref_pre", -1, pre);
    chk("ref_pre_after_ras", int'(pre - a2 >= 6), 1);
    chk("ref_pre_window", int'(pre > 150 && pre < 260), 1);
    exp_q.push_back({3'd5, 4'd0}); expect_cmd("ref_ref", pre + 3, rf);
    push_req(8'h2D);
    chk("ref_row_closed", row_open, 0);
    wait_pop("ref_late_pop", p);
    chk("ref_pop_after_rfc", p, rf + 9);
    exp_q.push_back({3'd1, 4'd5}); expect_cmd("ref_act", rf + 11, a);
    exp_q.push_back({3'd2, 4'd5}); expect_cmd("ref_rd", a + 3, r);

    // Back-to-back row-hit reads on row 5
    for (int i = 0; i < 4; i++) push_req({1'b0, 4'd5, b2b_col[i]});
    for (int i = 0; i < 4; i++) begin
      wait_pop($sformatf("b2b_pop%0d", i), b2b_pop[i]);
      if (i > 0) chk($sformatf("b2b_gap%0d", i), b2b_pop[i] - b2b_pop[i-1], 4);
      exp_q.push_back({3'd2, 1'b0, b2b_col[i]});
      expect_cmd($sformatf("b2b_rd%0d", i), b2b_pop[i] + 2, r);
    end
    repeat (20) @(negedge clk);
    chk("b2b_no_extra_pop", pop_log.size() - pop_rd, 0);
    chk("b2b_no_extra_cmd", cmd_cyc_log.size() - cmd_rd, 0);

    // Reset asserted in WAIT_RCD aborts the sequence
    push_req(8'h39);
    wait_pop("abort_pop", p);
    exp_q.push_back({3'd4, 4'd0}); expect_cmd("abort_pre", p + 2, pre);
    exp_q.push_back({3'd1, 4'd7}); expect_cmd("abort_act", pre + 3, a);
    #1;
    chk("abort_in_wait_rcd", dbg_state, 6);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_cmd", cmd, 0);
    chk("abort_state", dbg_state, 0);
    chk("abort_row_open", row_open, 0);
    chk("abort_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    chk("abort_no_cmd", cmd_cyc_log.size() - cmd_rd, 0);
    chk("abort_no_pop", pop_log.size() - pop_rd, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
